// File: rtl/sram_bank_responder.sv
// sram_bank_responder
//   A bank of Nums_SRAM independent single-clock SRAMs that serve the
//   dot-product memory controller. Every access moves Para_Deg consecutive
//   words starting at a base address, with modulo-Ram_Depth wrap. Read data
//   is registered and has a one-cycle valid pulse. Each SRAM has its own
//   zero-fill sweep, started by Mem_Clear.
//
// Ports
//   clk            clock
//   Mem_reset_n    asynchronous active-low reset
//   En_Chip_Select per-SRAM chip select
//   En_Read        per-SRAM read enable
//   En_Write       per-SRAM write enable
//   Addr_Read      per-SRAM read base address, slice i = [i*Addr_Width +: Addr_Width]
//   Addr_Write     per-SRAM write base address, same slicing
//   Data_In        write data, SRAM i word k = [(i*Para_Deg+k)*Data_Width +: Data_Width]
//   Mem_Clear      per-SRAM zero-fill request
//   Data_Out       registered read data, same slicing as Data_In
//   Data_Valid     one-cycle pulse when the Data_Out slice updates
//   Clear_Busy     high while the SRAM's zero-fill sweep runs
//
// Clear FSM (one per SRAM)
//   state    | meaning
//   IDLE     | accesses are accepted; Mem_Clear starts a sweep
//   CLEARING | zeroing Para_Deg words per cycle; accesses are dropped

module sram_bank_responder #(
    parameter int Addr_Width = 4,
    parameter int Ram_Depth  = 1 << Addr_Width,
    parameter int Nums_SRAM  = 3,
    parameter int Data_Width = 8,
    parameter int Para_Deg   = 2
) (
    input  logic                                      clk,
    input  logic                                      Mem_reset_n,
    input  logic [Nums_SRAM-1:0]                      En_Chip_Select,
    input  logic [Nums_SRAM-1:0]                      En_Read,
    input  logic [Nums_SRAM-1:0]                      En_Write,
    input  logic [Nums_SRAM*Addr_Width-1:0]           Addr_Read,
    input  logic [Nums_SRAM*Addr_Width-1:0]           Addr_Write,
    input  logic [Nums_SRAM*Para_Deg*Data_Width-1:0]  Data_In,
    input  logic [Nums_SRAM-1:0]                      Mem_Clear,
    output logic [Nums_SRAM*Para_Deg*Data_Width-1:0]  Data_Out,
    output logic [Nums_SRAM-1:0]                      Data_Valid,
    output logic [Nums_SRAM-1:0]                      Clear_Busy
);

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_t;

    // Base of the final sweep block, and the per-cycle sweep step.
    localparam logic [Addr_Width-1:0] LastBlock = Addr_Width'(Ram_Depth - Para_Deg);
    localparam logic [Addr_Width-1:0] Stride    = Addr_Width'(Para_Deg);

    for (genvar i = 0; i < Nums_SRAM; i++) begin : g_sram
        logic [Data_Width-1:0] mem [Ram_Depth];
        logic [Data_Width-1:0] rd_q [Para_Deg];
        clr_state_t            state;
        logic [Addr_Width-1:0] cnt;
        logic                  valid_q;
        logic [Addr_Width-1:0] rd_base;
        logic [Addr_Width-1:0] wr_base;
        logic                  rd_take;
        logic                  wr_take;

        assign rd_base = Addr_Read[i*Addr_Width +: Addr_Width];
        assign wr_base = Addr_Write[i*Addr_Width +: Addr_Width];
        assign rd_take = En_Chip_Select[i] & En_Read[i]  & (state == IDLE);
        assign wr_take = En_Chip_Select[i] & En_Write[i] & (state == IDLE);

        // Control state and read register. The read samples the array
        // before this edge's write lands, so overlapping accesses are
        // read-first.
        always_ff @(posedge clk or negedge Mem_reset_n) begin
            if (!Mem_reset_n) begin
                state   <= IDLE;
                cnt     <= '0;
                valid_q <= 1'b0;
                for (int k = 0; k < Para_Deg; k++) begin
                    rd_q[k] <= '0;
                end
            end else begin
                valid_q <= rd_take;
                if (rd_take) begin
                    for (int k = 0; k < Para_Deg; k++) begin
                        rd_q[k] <= mem[rd_base + Addr_Width'(k)];
                    end
                end
                case (state)
                    IDLE: begin
                        if (Mem_Clear[i]) begin
                            state <= CLEARING;
                            cnt   <= '0;
                        end
                    end
                    CLEARING: begin
                        if (cnt == LastBlock) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + Stride;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        // The array has no reset. A reset moves the FSM to IDLE at once,
        // so a sweep that is cut short leaves the unswept words intact.
        always_ff @(posedge clk) begin
            if (state == CLEARING) begin
                for (int k = 0; k < Para_Deg; k++) begin
                    mem[cnt + Addr_Width'(k)] <= '0;
                end
            end else if (wr_take) begin
                for (int k = 0; k < Para_Deg; k++) begin
                    mem[wr_base + Addr_Width'(k)] <= Data_In[(i*Para_Deg+k)*Data_Width +: Data_Width];
                end
            end
        end

        for (genvar k = 0; k < Para_Deg; k++) begin : g_word
            assign Data_Out[(i*Para_Deg+k)*Data_Width +: Data_Width] = rd_q[k];
        end

        assign Data_Valid[i] = valid_q;
        assign Clear_Busy[i] = (state == CLEARING);
    end

endmodule

// File: doc/sram_bank_responder.md
Name: sram_bank_responder

Overview:
- Bank of Nums_SRAM independent single-clock SRAMs. Responds to the chip-select, read/write-enable, address and clear strobes issued by the dot-product memory controller.
- Each access moves Para_Deg consecutive words, matching the controller's address stride.
- Provides registered read data with a valid flag. Runs a multi-cycle zero-fill sweep per SRAM when that SRAM's clear is requested.
- Sits between the memory controller and the dot-product datapath. Operand SRAMs feed the multipliers; the result SRAM receives sums.

Parameters:
Addr_Width, 4, address bits per SRAM
Ram_Depth, 1 << Addr_Width, words per SRAM
Nums_SRAM, 3, number of SRAM instances
Data_Width, 8, bits per word
Para_Deg, 2, words per access; must be a power of two dividing Ram_Depth

Ports:
clk  in  1  clock
Mem_reset_n  in  1  asynchronous active-low reset
En_Chip_Select  in  Nums_SRAM  per-SRAM chip select
En_Read  in  Nums_SRAM  per-SRAM read enable
En_Write  in  Nums_SRAM  per-SRAM write enable
Addr_Read  in  Nums_SRAM*Addr_Width  per-SRAM read base address; slice i = [i*Addr_Width +: Addr_Width]
Addr_Write  in  Nums_SRAM*Addr_Width  per-SRAM write base address, same slicing
Data_In  in  Nums_SRAM*Para_Deg*Data_Width  write data; SRAM i word k = [(i*Para_Deg+k)*Data_Width +: Data_Width]
Mem_Clear  in  Nums_SRAM  per-SRAM clear request, sampled each cycle
Data_Out  out  Nums_SRAM*Para_Deg*Data_Width  registered read data, same slicing as Data_In
Data_Valid  out  Nums_SRAM  one-cycle pulse per SRAM when its Data_Out slice updates
Clear_Busy  out  Nums_SRAM  high while the SRAM's zero-fill sweep is running

Behaviour:
- Reset (Mem_reset_n=0, asynchronous):
  - Data_Out=0, Data_Valid=0, Clear_Busy=0.
  - All clear FSMs go to IDLE; sweep counters go to 0.
  - Array contents are not reset: undefined at power-up, unchanged across reset.
- Reset mid-sweep: the sweep aborts immediately. Words not yet zeroed keep their old values.
- Write, SRAM i: taken at posedge when CS[i]&En_Write[i] and FSM_i=IDLE.
  - Word k of Data_In slice i goes to address (Addr_Write_i + k) mod Ram_Depth, for k = 0..Para_Deg-1.
- Read, SRAM i: taken at posedge when CS[i]&En_Read[i] and FSM_i=IDLE.
  - Word k comes from address (Addr_Read_i + k) mod Ram_Depth.
  - Latency 1: data appears on Data_Out slice i in the following cycle, with Data_Valid[i]=1 for exactly that cycle.
- With no read accepted: Data_Valid[i]=0 and Data_Out slice i holds its last value.
- Simultaneous read and write to overlapping addresses: read-first. The read returns the pre-write contents; the write still commits.
- Two write words landing on the same address cannot occur, because Para_Deg ≤ Ram_Depth.
- CS[i]=0: En_Read, En_Write and addresses are ignored for SRAM i.
- Clear FSM, per SRAM, states IDLE and CLEARING:
  - IDLE→CLEARING when Mem_Clear[i]=1. Sweep counter = 0; Clear_Busy[i]=1 from the next cycle.
  - Each CLEARING cycle writes zero to addresses cnt..cnt+Para_Deg-1, then cnt += Para_Deg.
  - When the sweep writes the last block (cnt = Ram_Depth-Para_Deg), the FSM returns to IDLE on that same edge, so Clear_Busy[i] is low in the following cycle.
  - Sweep length is exactly Ram_Depth/Para_Deg cycles.
  - Mem_Clear[i] asserted during CLEARING is ignored; there is no restart.
  - Mem_Clear[i] still high on return to IDLE starts a new sweep.
- During CLEARING: reads and writes to that SRAM are dropped silently and Data_Valid[i] stays 0. Other SRAMs are unaffected.
- Mem_Clear[i] and an access in the same IDLE cycle: the access is taken on that edge and the sweep starts on the same edge. A write is therefore later zeroed; a read returns the pre-clear data.
- Address arithmetic is Addr_Width bits and wraps naturally, e.g. base 15 with Para_Deg 2 touches 15 and 0.

Test Plan:
- Reset, then Mem_Clear=3'b111 for 1 cycle -> Clear_Busy=3'b111 for exactly 8 cycles (defaults); then reads of any address on all SRAMs -> Data_Out all zero, Data_Valid pulses 1 cycle after each read.
- SRAM0 write at Addr_Write=4 with words {0x11,0x22}; next cycle read at Addr_Read=4 -> one cycle later Data_Out slice0 = {0x11,0x22}, Data_Valid=3'b001 for one cycle; slice0 then holds while idle.
- Wrap case: SRAM2 write at address 15 with words {0xAA,0xBB}; read at 15 -> {0xAA,0xBB}; read at 0 -> word0=0xBB.
- Read-first: SRAM1 holds 0x05 at address 6; in one cycle, write 0x09 to address 6 and read address 6 -> Data_Out returns 0x05; a later read of address 6 returns 0x09.
- Clear with contention: fill SRAM1 with 0xFF, pulse Mem_Clear[1], then issue SRAM1 writes and reads and a second Mem_Clear[1] during the sweep -> no Data_Valid[1]; busy stays 8 cycles with no restart; afterwards all SRAM1 words read 0; SRAM0 accesses run normally throughout.
- Mid-sweep reset: pulse Mem_reset_n low 3 cycles into a sweep of SRAM0 pre-filled with 0x33 -> Clear_Busy=0 and Data_Valid=0 immediately; addresses 0-5 read 0, addresses 6-15 read 0x33.
